// File: rtl/ssio_ddr_in_calib.sv
// Tap-sweep calibration controller for a source-synchronous DDR input stage.
// Sweeps the input-delay tap across NUM_TAPS settings, checks the captured
// q1/q2 words against a fixed training pattern at each tap, then loads the
// centre of the longest passing window (or the mid tap if none qualifies).
// Optional build macro: SSIO_DDR_IN_CALIB_MONITOR_EN -- while locked, keep
// watching the pattern and re-run the sweep after 16 consecutive mismatches.
module ssio_ddr_in_calib #(
  parameter int               WIDTH         = 5,
  parameter int               TAP_W         = 5,
  parameter int               NUM_TAPS      = 32,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               CHECK_CYCLES  = 64,
  parameter int               MIN_WINDOW    = 4,
  parameter logic [WIDTH-1:0] PATTERN_Q1    = 5'h15,
  parameter logic [WIDTH-1:0] PATTERN_Q2    = 5'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  output logic [TAP_W-1:0] tap_value,
  output logic             tap_ld,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             fail,
  output logic [TAP_W:0]   window_len
);

  // Handshake: start is a one-cycle request, honoured only in IDLE or DONE
  // (busy=0); tap_ld is a one-cycle strobe that the delay element must act on
  // in the cycle it is high -- there is no back-pressure.

  localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] MID_TAP    = TAP_W'(NUM_TAPS / 2);
  localparam logic [TAP_W:0]   MIN_LEN    = (TAP_W+1)'(MIN_WINDOW);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_END  = CNT_W'(CHECK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_CENTER, S_DONE
  } state_t;

  // Current state is kept as a named signal so checkers can bind to it.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tap_ok;
  logic             run_open;
  logic [TAP_W-1:0] run_start;
  logic [TAP_W:0]   run_len;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;

  logic             sample_ok;
  logic             last_tap;
  logic             run_close;
  logic [TAP_W:0]   eval_len;
  logic [TAP_W-1:0] eval_start;
  logic             new_best;
  logic             mon_trip;
  logic             restart;

`ifdef SSIO_DDR_IN_CALIB_MONITOR_EN
  logic [4:0] miss_cnt;
`endif

  // Per-sample pattern check and the run/best bookkeeping for the EVAL step.
  always_comb begin
    sample_ok  = (q1 == PATTERN_Q1) && (q2 == PATTERN_Q2);
    last_tap   = (tap_value == LAST_TAP);
    run_close  = !tap_ok || last_tap;
    eval_len   = run_len;
    eval_start = run_start;
    if (tap_ok) begin
      eval_len   = run_open ? run_len + 1'b1 : {{TAP_W{1'b0}}, 1'b1};
      eval_start = run_open ? run_start : tap_value;
    end
    // Strictly greater: the first longest run found keeps the crown.
    new_best = run_close && (eval_len > best_len);
    mon_trip = 1'b0;
`ifdef SSIO_DDR_IN_CALIB_MONITOR_EN
    mon_trip = (state == S_DONE) && locked && !sample_ok && (miss_cnt == 5'd15);
`endif
    restart  = (start && (state == S_IDLE || state == S_DONE)) || mon_trip;
  end

  // Calibration FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tap_ok     <= 1'b0;
      run_open   <= 1'b0;
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      tap_value  <= '0;
      tap_ld     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      window_len <= '0;
`ifdef SSIO_DDR_IN_CALIB_MONITOR_EN
      miss_cnt   <= '0;
`endif
    end else begin
      tap_ld <= 1'b0;
      if (restart) begin
        // Fresh sweep from tap 0; the LOAD cycle carries the tap_ld strobe.
        state      <= S_LOAD;
        cnt        <= '0;
        run_open   <= 1'b0;
        run_start  <= '0;
        run_len    <= '0;
        best_start <= '0;
        best_len   <= '0;
        tap_value  <= '0;
        tap_ld     <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        locked     <= 1'b0;
        fail       <= 1'b0;
`ifdef SSIO_DDR_IN_CALIB_MONITOR_EN
        miss_cnt   <= '0;
`endif
      end else begin
        case (state)
          S_LOAD: begin
            cnt   <= '0;
            state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt == SETTLE_END) begin
              cnt    <= '0;
              tap_ok <= 1'b1;
              state  <= S_CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CHECK: begin
            // A mismatch fails the tap, but the full sample count still runs.
            if (!sample_ok) tap_ok <= 1'b0;
            if (cnt == CHECK_END) begin
              cnt   <= '0;
              state <= S_EVAL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_EVAL: begin
            if (new_best) begin
              best_start <= eval_start;
              best_len   <= eval_len;
            end
            if (run_close) begin
              run_open <= 1'b0;
              run_len  <= '0;
            end else begin
              run_open  <= 1'b1;
              run_start <= eval_start;
              run_len   <= eval_len;
            end
            if (!last_tap) begin
              tap_value <= tap_value + 1'b1;
              tap_ld    <= 1'b1;
              state     <= S_LOAD;
            end else begin
              state <= S_CENTER;
            end
          end
          S_CENTER: begin
            if (best_len >= MIN_LEN) begin
              tap_value <= best_start + TAP_W'((best_len - 1'b1) >> 1);
              locked    <= 1'b1;
            end else begin
              tap_value <= MID_TAP;
              fail      <= 1'b1;
            end
            tap_ld     <= 1'b1;
            window_len <= best_len;
            busy       <= 1'b0;
            done       <= 1'b1;
`ifdef SSIO_DDR_IN_CALIB_MONITOR_EN
            miss_cnt   <= '0;
`endif
            state      <= S_DONE;
          end
          S_DONE: begin
`ifdef SSIO_DDR_IN_CALIB_MONITOR_EN
            if (locked) begin
              if (sample_ok) miss_cnt <= '0;
              else           miss_cnt <= miss_cnt + 1'b1;
            end
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
